uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/arch_defs_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_mmio.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map, STATUS bits, FSM states.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are clog2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA/STATUS/CTRL registers, TX FIFO and 8N1 serialiser.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop (11-bit frame).
module uart_tx_mmio
  import arch_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [1:0]            reg_addr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tx,
  output logic                  irq_empty
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [15:0]           baud_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shifter;
  logic                  overflow;
  logic                  baud_done;
  logic                  busy;
  logic                  wr_en;
  logic                  rd_en;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [7:0]            status;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign wr_en     = sel & mem_write;
  assign rd_en     = sel & mem_read;
  assign fifo_push = wr_en && (reg_addr == REG_DATA);
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != TX_IDLE);
  assign irq_empty = fifo_empty && !busy;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  // STOP pops the next byte directly so queued frames leave with no idle gap.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = TX_START;
        end
      end
      TX_START: if (baud_done) state_next = TX_DATA;
      TX_DATA: begin
        if (baud_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = TX_PARITY;
`else
          state_next = TX_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: if (baud_done) state_next = TX_STOP;
`endif
      TX_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = TX_START;
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      overflow <= 1'b0;
    end else begin
      if (state_next != state || baud_done || state == TX_IDLE) baud_cnt <= '0;
      else                                                      baud_cnt <= baud_cnt + 16'd1;

      if (state == TX_DATA) begin
        if (baud_done) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= '0;
      end

      if (fifo_pop)                         shifter <= fifo_rdata;
      else if (state == TX_DATA && baud_done) shifter <= {1'b0, shifter[DATA_WIDTH-1:1]};

      if (fifo_push && fifo_full && !fifo_pop)             overflow <= 1'b1;
      else if (wr_en && reg_addr == REG_CTRL && data_in[0]) overflow <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is latched at load time because the shifter is consumed during DATA.
  always_ff @(posedge clk) begin
    if (reset)         parity_bit <= 1'b0;
    else if (fifo_pop) parity_bit <= ^fifo_rdata;
  end
`endif

  always_comb begin
    case (state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = shifter[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx = parity_bit;
`endif
      default:   tx = 1'b1;
    endcase
  end

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = busy;
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_OVERFLOW] = overflow;
  end

  always_comb begin
    data_out = '0;
    if (rd_en) begin
      case (reg_addr)
        REG_STATUS:                   data_out = status;
        REG_DATA, REG_CTRL, REG_RSVD: data_out = '0;
        default:                      data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vectors, directed frame/FIFO corner cases, random bursts
// decoded from the serial line by a frame-level monitor. Honours UART_TX_PARITY_EN for frame length.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tx;
  logic       irq_empty;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .reg_addr  (reg_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_in   (data_in),
    .data_out  (data_out),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         mon_starts = 0;
  logic       mon_busy = 1'b0;

  typedef struct {
    logic       sel_v;
    logic       rd;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; mem_write = 1'b1; reg_addr = a; data_in = d;
    @(posedge clk);
    #1;
    sel = 1'b0; mem_write = 1'b0; data_in = 8'h00; reg_addr = 2'd0;
  endtask

  task automatic read_reg(input logic s, input logic [1:0] a, output logic [7:0] d);
    sel = s; mem_read = 1'b1; reg_addr = a;
    #1;
    d = data_out;
    sel = 1'b0; mem_read = 1'b0; reg_addr = 2'd0;
  endtask

  task automatic check_status(input string name, input logic [7:0] expected);
    logic [7:0] d;
    read_reg(1'b1, A_STATUS, d);
    check_output(name, d, expected);
  endtask

  task automatic apply_stimulus(input vec_t v);
    sel = v.sel_v; mem_read = v.rd; mem_write = v.wr; reg_addr = v.addr; data_in = v.wdata;
    #1;
  endtask

  task automatic wait_idle();
    int budget = 20 * FRAME_CYC;
    while (!(irq_empty === 1'b1 && !mon_busy) && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) check_output("idle_timeout", 0, 1);
    step(2);
  endtask

  task automatic expect_frames(input string name);
    int budget = (exp_q.size() + 4) * FRAME_CYC;
    while (rx_q.size() < exp_q.size() && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) check_output({name, "_timeout"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check_output(name, rx_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
  endtask

  // Frame-level line decoder: every bit must hold for CPB cycles; a reset abandons the frame.
  initial begin : monitor
    logic [FRAME_BITS-1:0] bits;
    logic                  stable;
    logic                  aborted;
    logic [7:0]            byte_v;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      mon_busy = 1'b1;
      mon_starts++;
      start_q.push_back(cyc);
      stable = 1'b1; aborted = 1'b0; bits = '0;
      for (int b = 0; b < FRAME_BITS; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (c == 0) bits[b] = tx;
          else if (tx !== bits[b]) stable = 1'b0;
        end
        if (aborted) break;
      end
      mon_busy = 1'b0;
      if (aborted) continue;
      byte_v = bits[8:1];
      check_output("bit_stable", stable, 1);
      check_output("stop_bit", bits[FRAME_BITS-1], 1);
`ifdef UART_TX_PARITY_EN
      check_output("parity_bit", bits[9], ^byte_v);
`endif
      rx_q.push_back(byte_v);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] d;
    logic [7:0] burst6[6];
    logic       busy_ok;
    int         w;
    int         starts0;
    int         n;
    logic [7:0] b;

    burst6 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

    vecs[0]  = '{1'b1, 1'b1, 1'b0, A_STATUS, 8'h00, 8'h04};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, A_DATA,   8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, A_CTRL,   8'h00, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, A_RSVD,   8'h00, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, A_STATUS, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, A_STATUS, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, A_CTRL,   8'hFF, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, A_STATUS, 8'hAA, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, A_RSVD,   8'h55, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, A_DATA,   8'h12, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 1'b0, A_STATUS, 8'h00, 8'h04};

    reset = 1'b1;
    step(3);
    check_output("reset_tx", tx, 1);
    check_output("reset_irq_empty", irq_empty, 1);
    check_status("reset_status", 8'h04);
    reset = 1'b0;
    step(1);

    // Register map and ignored accesses: nothing here may start a frame.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_dout);
      check_output($sformatf("vec%0d_tx", i), tx, 1);
      check_output($sformatf("vec%0d_irq", i), irq_empty, 1);
      @(posedge clk);
      #1;
      sel = 1'b0; mem_read = 1'b0; mem_write = 1'b0; data_in = 8'h00; reg_addr = 2'd0;
    end
    check_output("vec_no_frames", mon_starts, 0);

    // Single frame: start one cycle after the pop, BUSY for the whole frame.
    wait_idle();
    start_q.delete();
    write_reg(A_DATA, 8'h55);
    w = cyc;
    exp_q.push_back(8'h55);
    busy_ok = 1'b1;
    for (int k = 1; k <= FRAME_CYC; k++) begin
      step(1);
      read_reg(1'b1, A_STATUS, d);
      if (d[0] !== 1'b1) busy_ok = 1'b0;
    end
    check_output("busy_during_frame", busy_ok, 1);
    step(1);
    check_status("status_after_frame", 8'h04);
    check_output("irq_after_frame", irq_empty, 1);
    check_output("single_start_count", start_q.size(), 1);
    if (start_q.size() > 0) check_output("single_start_cycle", start_q[0], w + 1);
    expect_frames("single_byte");

    // Six back-to-back writes: one popped, four queued, sixth dropped.
    wait_idle();
    start_q.delete();
    for (int i = 0; i < 6; i++) write_reg(A_DATA, burst6[i]);
    check_status("burst_status_overflow", 8'h0B);
    for (int i = 0; i < 5; i++) exp_q.push_back(burst6[i]);
    expect_frames("burst_byte");
    check_output("burst_start_count", start_q.size(), 5);
    for (int i = 1; i < 5 && i < start_q.size(); i++)
      check_output($sformatf("burst_gap%0d", i), start_q[i] - start_q[i-1], FRAME_CYC);
    wait_idle();
    check_status("burst_status_done", 8'h0C);
    write_reg(A_CTRL, 8'h02);
    check_status("ctrl_bit1_no_clear", 8'h0C);
    write_reg(A_CTRL, 8'h01);
    check_status("ctrl_clear", 8'h04);
    check_output("burst_no_extra", rx_q.size(), 0);

    // Write lands on the same edge as the STOP->START pop while full.
    wait_idle();
    write_reg(A_DATA, 8'h11);
    w = cyc;
    write_reg(A_DATA, 8'h22);
    write_reg(A_DATA, 8'h33);
    write_reg(A_DATA, 8'h44);
    write_reg(A_DATA, 8'h55);
    check_status("full_status", 8'h03);
    while (cyc < w + FRAME_CYC) step(1);
    write_reg(A_DATA, 8'h66);
    check_status("pop_push_accepted", 8'h03);
    write_reg(A_DATA, 8'h77);
    check_status("full_drop", 8'h0B);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expect_frames("popwrite_byte");
    wait_idle();
    write_reg(A_CTRL, 8'h01);
    check_status("popwrite_clear", 8'h04);
    check_output("popwrite_no_extra", rx_q.size(), 0);

    // Reset mid-DATA with two bytes queued.
    wait_idle();
    write_reg(A_DATA, 8'hC0);
    w = cyc;
    write_reg(A_DATA, 8'hC1);
    write_reg(A_DATA, 8'hC2);
    while (cyc < w + 12) step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_output("midreset_tx", tx, 1);
    check_output("midreset_irq", irq_empty, 1);
    check_status("midreset_status", 8'h04);
    starts0 = mon_starts;
    step(3 * FRAME_CYC);
    check_output("midreset_no_frames", mon_starts, starts0);
    check_output("midreset_no_bytes", rx_q.size(), 0);
    check_output("midreset_tx_idle", tx, 1);

    // Random bursts that cannot overflow; model tracks bytes and occupancy.
    for (int r = 0; r < 8; r++) begin
      wait_idle();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        write_reg(A_DATA, b);
        exp_q.push_back(b);
        if ($urandom_range(0, 1) == 1) begin
          read_reg(1'b0, A_STATUS, d);
          check_output("rand_unselected_read", d, 0);
        end else begin
          read_reg(1'b1, A_RSVD, d);
          check_output("rand_reserved_read", d, 0);
        end
        step($urandom_range(0, 3));
      end
      step(1);
      check_status($sformatf("rand_status_n%0d", n), (n == 1) ? 8'h05 : 8'h01);
      expect_frames("rand_byte");
      wait_idle();
      check_output("rand_no_extra", rx_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
